// File: rtl/hex_sr_pkg.sv
// -----------------------------------------------------------------------------
// hex_sr_pkg
// Shared definitions for the recirculating hex shift register array and its
// load/readback controller.
//   HEX_SR_WIDTH   : lanes per slot (bits per stored word)
//   HEX_SR_LENGTH  : stages per lane (number of addressable slots)
//   hex_sr_state_e : controller operating mode
// -----------------------------------------------------------------------------
package hex_sr_pkg;

   localparam int HEX_SR_WIDTH  = 6;
   localparam int HEX_SR_LENGTH = 70;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      READ = 2'd2
   } hex_sr_state_e;

endpackage : hex_sr_pkg

// File: rtl/hex_sr_pos_ctr.sv
// -----------------------------------------------------------------------------
// hex_sr_pos_ctr
// Modulo-LENGTH up-counter tracking which slot is currently at the array output.
// Advances on every clk edge, in lock-step with the array rotation.
//   clk   : system clock (shared with the shift register array)
//   rst   : synchronous, active-high reset; forces count to 0
//   count : current slot index, 0..LENGTH-1
// -----------------------------------------------------------------------------
module hex_sr_pos_ctr
   import hex_sr_pkg::*;
#(
   parameter int LENGTH = HEX_SR_LENGTH,
   parameter int CW     = $clog2(LENGTH)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 32'd1);
   localparam logic [CW-1:0] ONE      = CW'(32'd1);

   logic [CW-1:0] count_r;

   // Slot counter: wraps from LENGTH-1 back to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {CW{1'b0}};
      end else if (count_r == LAST_IDX) begin
         count_r <= {CW{1'b0}};
      end else begin
         count_r <= count_r + ONE;
      end
   end

   assign count = count_r;

endmodule : hex_sr_pos_ctr

// File: rtl/hex_sr_ctrl.sv
// -----------------------------------------------------------------------------
// hex_sr_ctrl
// Load/readback controller for the recirculating hex shift register array.
// Maps the free-running rotation onto addressable slots: a write stream fills
// slots 0..LENGTH-1 in order, a read stream drains them in order.
//   clk, rst            : shared clock, synchronous active-high reset
//   load_start          : pulse, start loading slots 0..LENGTH-1
//   read_start          : pulse, start reading slots 0..LENGTH-1
//   in_valid/in_data    : write stream from producer
//   in_ready            : write word accepted this cycle
//   out_valid/out_data  : read stream to consumer
//   out_ready           : consumer takes the read word
//   sr_recirc/sr_data   : to the array (1 = recirculate, 0 = shift in sr_data)
//   sr_q                : array output, holds the word of slot pos
//   pos                 : slot index currently at the array output
//   busy                : an operation is in progress
//   done                : one-cycle pulse after the last transfer
// -----------------------------------------------------------------------------
module hex_sr_ctrl
   import hex_sr_pkg::*;
#(
   parameter  int LENGTH = HEX_SR_LENGTH,
   parameter  int WIDTH  = HEX_SR_WIDTH,
   localparam int CW     = $clog2(LENGTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_start,
   input  logic             read_start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             sr_recirc,
   output logic [WIDTH-1:0] sr_data,
   input  logic [WIDTH-1:0] sr_q,
   output logic [CW-1:0]    pos,
   output logic             busy,
   output logic             done
);

   localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 32'd1);
   localparam logic [CW-1:0] ONE      = CW'(32'd1);

   hex_sr_state_e  state_r, state_s;
   logic [CW-1:0]  wr_idx_r, wr_idx_s;
   logic [CW-1:0]  rd_idx_r, rd_idx_s;
   logic           done_r, done_s;
   logic           busy_r;
   logic [CW-1:0]  pos_s;
   logic           wr_slot_s;
   logic           rd_slot_s;

   hex_sr_pos_ctr #(
      .LENGTH (LENGTH),
      .CW     (CW)
   ) u_pos_ctr (
      .clk   (clk),
      .rst   (rst),
      .count (pos_s)
   );

   // The next slot to fill/drain is only reachable while it sits at the output.
   assign wr_slot_s = (pos_s == wr_idx_r);
   assign rd_slot_s = (pos_s == rd_idx_r);

   // Next-state and array/stream drive; every slot not being written recirculates.
   always_comb begin
      state_s   = state_r;
      wr_idx_s  = wr_idx_r;
      rd_idx_s  = rd_idx_r;
      done_s    = 1'b0;
      sr_recirc = 1'b1;
      sr_data   = {WIDTH{1'b0}};
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = {WIDTH{1'b0}};
      case (state_r)
         IDLE: begin
            // Load has priority; a coincident read_start is dropped.
            if (load_start) begin
               state_s  = LOAD;
               wr_idx_s = {CW{1'b0}};
            end else if (read_start) begin
               state_s  = READ;
               rd_idx_s = {CW{1'b0}};
            end else begin
               state_s  = IDLE;
            end
         end
         LOAD: begin
            in_ready = wr_slot_s;
            if (in_valid && wr_slot_s) begin
               sr_recirc = 1'b0;
               sr_data   = in_data;
               if (wr_idx_r == LAST_IDX) begin
                  state_s  = IDLE;
                  done_s   = 1'b1;
                  wr_idx_s = {CW{1'b0}};
               end else begin
                  wr_idx_s = wr_idx_r + ONE;
               end
            end else begin
               // Missed window: the same slot comes round again LENGTH cycles on.
               wr_idx_s = wr_idx_r;
            end
         end
         READ: begin
            out_valid = rd_slot_s;
            if (rd_slot_s) begin
               out_data = sr_q;
            end else begin
               out_data = {WIDTH{1'b0}};
            end
            if (rd_slot_s && out_ready) begin
               if (rd_idx_r == LAST_IDX) begin
                  state_s  = IDLE;
                  done_s   = 1'b1;
                  rd_idx_s = {CW{1'b0}};
               end else begin
                  rd_idx_s = rd_idx_r + ONE;
               end
            end else begin
               rd_idx_s = rd_idx_r;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, indices and registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         wr_idx_r <= {CW{1'b0}};
         rd_idx_r <= {CW{1'b0}};
         done_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         wr_idx_r <= wr_idx_s;
         rd_idx_r <= rd_idx_s;
         done_r   <= done_s;
         busy_r   <= (state_s != IDLE);
      end
   end

   assign pos  = pos_s;
   assign busy = busy_r;
   assign done = done_r;

endmodule : hex_sr_ctrl

// File: tb/tb_hex_sr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hex_sr_ctrl
// Self-checking bench for hex_sr_ctrl with a behavioural recirculating array.
// Write handshakes record expected slot contents; a read pushes them into a
// scoreboard queue that is popped on each read handshake.
// -----------------------------------------------------------------------------
module tb_hex_sr_ctrl;
   import hex_sr_pkg::*;

   localparam int L  = HEX_SR_LENGTH;
   localparam int W  = HEX_SR_WIDTH;
   localparam int CW = $clog2(L);

   logic          clk        = 1'b0;
   logic          rst        = 1'b1;
   logic          load_start = 1'b0;
   logic          read_start = 1'b0;
   logic          in_valid   = 1'b0;
   logic [W-1:0]  in_data    = '0;
   logic          out_ready  = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          sr_recirc;
   logic [W-1:0]  sr_data;
   logic [W-1:0]  sr_q;
   logic [CW-1:0] pos;
   logic          busy;
   logic          done;

   logic [W-1:0]  arr [0:L-1];
   logic [W-1:0]  mem [0:L-1];
   logic [W-1:0]  exp_q [$];
   int            exp_pos = 0;
   int            cyc     = 0;
   int            n_tests = 0;
   int            n_fail  = 0;

   always #5 clk = ~clk;

   hex_sr_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .read_start (read_start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .sr_recirc  (sr_recirc),
      .sr_data    (sr_data),
      .sr_q       (sr_q),
      .pos        (pos),
      .busy       (busy),
      .done       (done)
   );

   // Array model: LENGTH-deep recirculating lanes, not affected by rst.
   assign sr_q = arr[L-1];
   always @(posedge clk) begin
      arr[0] <= sr_recirc ? sr_q : sr_data;
      for (int k = 1; k < L; k++) arr[k] <= arr[k-1];
   end

   // Reference slot position and cycle counter.
   always @(posedge clk) begin
      if (rst) exp_pos <= 0;
      else     exp_pos <= (exp_pos == L - 1) ? 0 : exp_pos + 1;
      cyc <= cyc + 1;
   end

   task automatic check_eq(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Load all slots with (index+ofs) mod 64; optionally skip one offer or abort by rst.
   task automatic do_load(input bit with_read, input int ofs, input int miss_slot,
                          input int abort_at);
      int wr_cnt    = 0;
      bit missed    = 1'b0;
      int miss_cyc  = -1;
      int first_cyc = -1;
      int last_cyc  = -1;
      bit fin       = 1'b0;
      @(posedge clk); #1;
      load_start = 1'b1;
      read_start = with_read;
      check_eq("idle_in_ready", int'(in_ready), 0);
      for (int t = 0; t < 4 * L && !fin; t++) begin
         @(posedge clk); #1;
         load_start = 1'b0;
         read_start = 1'b0;
         check_eq("load_out_valid", int'(out_valid), 0);
         if (wr_cnt == L) begin
            in_valid = 1'b0;
            check_eq("load_done", int'(done), 1);
            check_eq("load_busy_end", int'(busy), 0);
            check_eq("load_in_ready_end", int'(in_ready), 0);
            if (miss_slot < 0) check_eq("load_span", last_cyc - first_cyc, L - 1);
            @(posedge clk); #1;
            check_eq("load_done_pulse", int'(done), 0);
            fin = 1'b1;
         end else if (wr_cnt == abort_at) begin
            rst      = 1'b1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            check_eq("rst_pos", int'(pos), 0);
            check_eq("rst_busy", int'(busy), 0);
            check_eq("rst_done", int'(done), 0);
            check_eq("rst_in_ready", int'(in_ready), 0);
            check_eq("rst_recirc", int'(sr_recirc), 1);
            @(posedge clk); #1;
            check_eq("rst_done2", int'(done), 0);
            check_eq("rst_pos2", int'(pos), 1);
            fin = 1'b1;
         end else begin
            check_eq("load_busy", int'(busy), 1);
            check_eq("in_ready", int'(in_ready), int'(exp_pos == wr_cnt));
            in_data = W'((wr_cnt + ofs) % 64);
            if (in_ready && wr_cnt == miss_slot && !missed) begin
               in_valid = 1'b0;
               missed   = 1'b1;
               miss_cyc = cyc;
            end else begin
               in_valid = 1'b1;
               if (in_ready) begin
                  if (wr_cnt == miss_slot) begin
                     check_eq("miss_retry_gap", cyc - miss_cyc, L);
                     check_eq("miss_retry_pos", int'(pos), miss_slot);
                  end
                  #1;
                  check_eq("wr_recirc", int'(sr_recirc), 0);
                  check_eq("wr_sr_data", int'(sr_data), int'(in_data));
                  if (first_cyc < 0) first_cyc = cyc;
                  last_cyc    = cyc;
                  mem[wr_cnt] = in_data;
                  wr_cnt++;
               end
            end
         end
      end
      in_valid = 1'b0;
      if (!fin) check_eq("load_timeout", wr_cnt, L);
   endtask

   // Read all slots; optionally refuse the first offer of one slot.
   task automatic do_read(input int bp_slot);
      int rd_cnt = 0;
      bit bp     = 1'b0;
      int bp_cyc = -1;
      bit fin    = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      read_start = 1'b1;
      out_ready  = 1'b1;
      for (int i = 0; i < L; i++) exp_q.push_back(mem[i]);
      for (int t = 0; t < 4 * L && !fin; t++) begin
         @(posedge clk); #1;
         read_start = 1'b0;
         check_eq("read_in_ready", int'(in_ready), 0);
         check_eq("read_recirc", int'(sr_recirc), 1);
         if (rd_cnt == L) begin
            check_eq("read_done", int'(done), 1);
            check_eq("read_busy_end", int'(busy), 0);
            check_eq("read_valid_end", int'(out_valid), 0);
            check_eq("read_q_left", exp_q.size(), 0);
            @(posedge clk); #1;
            check_eq("read_done_pulse", int'(done), 0);
            fin = 1'b1;
         end else begin
            check_eq("read_busy", int'(busy), 1);
            check_eq("out_valid", int'(out_valid), int'(exp_pos == rd_cnt));
            if (out_valid) begin
               if (rd_cnt == bp_slot && !bp) begin
                  out_ready = 1'b0;
                  bp        = 1'b1;
                  bp_cyc    = cyc;
               end else begin
                  out_ready = 1'b1;
                  if (rd_cnt == bp_slot) check_eq("bp_retry_gap", cyc - bp_cyc, L);
                  check_eq("read_q_avail", int'(exp_q.size() > 0), 1);
                  if (exp_q.size() > 0) check_eq("out_data", int'(out_data), int'(exp_q.pop_front()));
                  rd_cnt++;
               end
            end else begin
               out_ready = 1'b1;
               check_eq("out_data_idle", int'(out_data), 0);
            end
         end
      end
      out_ready = 1'b0;
      if (!fin) check_eq("read_timeout", rd_cnt, L);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_pos", int'(pos), 0);
      check_eq("reset_recirc", int'(sr_recirc), 1);
      check_eq("reset_sr_data", int'(sr_data), 0);
      check_eq("reset_in_ready", int'(in_ready), 0);
      check_eq("reset_out_valid", int'(out_valid), 0);
      check_eq("reset_out_data", int'(out_data), 0);
      check_eq("reset_busy", int'(busy), 0);
      check_eq("reset_done", int'(done), 0);
      rst = 1'b0;
      for (int i = 0; i <= L; i++) begin
         check_eq("pos_count", int'(pos), i % L);
         @(posedge clk); #1;
      end

      // Full load and readback.
      do_load(1'b0, 0, -1, -1);
      do_read(-1);
      // Missed write slot 10, then backpressure on read slot 3.
      do_load(1'b0, 0, 10, -1);
      do_read(3);
      // Simultaneous starts: load wins, no read stream during it.
      do_load(1'b1, 17, -1, -1);
      do_read(-1);
      // Reset mid-load, then a fresh full load and readback.
      do_load(1'b0, 0, -1, 35);
      do_load(1'b0, 5, -1, -1);
      do_read(-1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_hex_sr_ctrl
